// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: circular FIFO of {instruction, PC+4} between fetch and decode.
// The head entry drives the ID outputs combinationally; an empty queue presents a NOP.
module if_id_queue #(
  parameter int unsigned       DATA_W  = 32,
  parameter int unsigned       ADDR_W  = 32,
  parameter int unsigned       DEPTH   = 4,
  parameter logic [DATA_W-1:0] NOP_INS = DATA_W'(32'h00000013)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       pipeline_stall,
  input  logic                       if_valid_in,
  input  logic [DATA_W-1:0]          if_ins_in,
  input  logic [ADDR_W-1:0]          if_pc_plus_4_in,
  output logic                       if_ready_out,
  output logic                       id_valid_out,
  output logic [DATA_W-1:0]          id_ins_out,
  output logic [ADDR_W-1:0]          id_pc_plus_4_out,
  output logic [$clog2(DEPTH+1)-1:0] count_out
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] ins_q [DEPTH];
  logic [ADDR_W-1:0] pc_q  [DEPTH];

  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic push, pop;

  // Ready and valid come from the registered count only, so there is no bypass path.
  assign if_ready_out = (count_q < CntW'(DEPTH));
  assign id_valid_out = (count_q != '0);

  assign push = if_valid_in & if_ready_out & ~flush;
  assign pop  = id_valid_out & ~pipeline_stall & ~flush;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + PtrW'(1);
      if (pop)  rptr_d = rptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage is intentionally unreset; stale slots are never visible because valid gates them.
  always_ff @(posedge clk) begin
    if (push) begin
      ins_q[wptr_q] <= if_ins_in;
      pc_q[wptr_q]  <= if_pc_plus_4_in;
    end
  end

  always_comb begin
    id_ins_out       = NOP_INS;
    id_pc_plus_4_out = '0;
    if (id_valid_out) begin
      id_ins_out       = ins_q[rptr_q];
      id_pc_plus_4_out = pc_q[rptr_q];
    end
  end

  assign count_out = count_q;

endmodule

// File: tb/tb_if_id_queue.sv
// Directed, table-driven bench for if_id_queue: each vector is applied for one clock
// and the outputs after that edge are compared against hand-computed values.
module tb_if_id_queue;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DEPTH  = 4;
  localparam logic [31:0] NOP    = 32'h00000013;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              pipeline_stall;
  logic              if_valid_in;
  logic [DATA_W-1:0] if_ins_in;
  logic [ADDR_W-1:0] if_pc_plus_4_in;
  logic              if_ready_out;
  logic              id_valid_out;
  logic [DATA_W-1:0] id_ins_out;
  logic [ADDR_W-1:0] id_pc_plus_4_out;
  logic [2:0]        count_out;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  if_id_queue #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .NOP_INS(NOP)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .flush           (flush),
    .pipeline_stall  (pipeline_stall),
    .if_valid_in     (if_valid_in),
    .if_ins_in       (if_ins_in),
    .if_pc_plus_4_in (if_pc_plus_4_in),
    .if_ready_out    (if_ready_out),
    .id_valid_out    (id_valid_out),
    .id_ins_out      (id_ins_out),
    .id_pc_plus_4_out(id_pc_plus_4_out),
    .count_out       (count_out)
  );

  typedef struct {
    logic        flush;
    logic        stall;
    logic        valid;
    logic [31:0] ins;
    logic [31:0] pc;
    int          exp_count;
    logic        exp_valid;
    logic [31:0] exp_ins;
    logic [31:0] exp_pc;
    logic        exp_ready;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic fl, input logic st, input logic vl, input logic [31:0] ins,
                     input logic [31:0] pc, input int cnt, input logic evl,
                     input logic [31:0] eins, input logic [31:0] epc, input logic erdy);
    vec_t v;
    v.flush = fl; v.stall = st; v.valid = vl; v.ins = ins; v.pc = pc;
    v.exp_count = cnt; v.exp_valid = evl; v.exp_ins = eins; v.exp_pc = epc;
    v.exp_ready = erdy;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int cnt, input logic vl,
                           input logic [31:0] ins, input logic [31:0] pc, input logic rdy);
    check({tag, "_count"}, 64'(count_out), 64'(cnt));
    check({tag, "_valid"}, 64'(id_valid_out), 64'(vl));
    check({tag, "_ins"},   64'(id_ins_out), 64'(ins));
    check({tag, "_pc"},    64'(id_pc_plus_4_out), 64'(pc));
    check({tag, "_ready"}, 64'(if_ready_out), 64'(rdy));
  endtask

  task automatic drive(input logic fl, input logic st, input logic vl,
                       input logic [31:0] ins, input logic [31:0] pc);
    flush = fl; pipeline_stall = st; if_valid_in = vl; if_ins_in = ins; if_pc_plus_4_in = pc;
  endtask

  initial begin
    // Fill under stall, fifth push dropped, then drain in order.
    add(0, 1, 1, 32'hA0, 32'd4,  1, 1, 32'hA0, 32'd4, 1);
    add(0, 1, 1, 32'hA1, 32'd8,  2, 1, 32'hA0, 32'd4, 1);
    add(0, 1, 1, 32'hA2, 32'd12, 3, 1, 32'hA0, 32'd4, 1);
    add(0, 1, 1, 32'hA3, 32'd16, 4, 1, 32'hA0, 32'd4, 0);
    add(0, 1, 1, 32'hA4, 32'd20, 4, 1, 32'hA0, 32'd4, 0);
    add(0, 0, 0, 32'h0,  32'd0,  3, 1, 32'hA1, 32'd8, 1);
    add(0, 0, 0, 32'h0,  32'd0,  2, 1, 32'hA2, 32'd12, 1);
    add(0, 0, 0, 32'h0,  32'd0,  1, 1, 32'hA3, 32'd16, 1);
    add(0, 0, 0, 32'h0,  32'd0,  0, 0, NOP,    32'd0, 1);
    // Single entry held through a 5-cycle stall, popped on release.
    add(0, 1, 1, 32'h00500093, 32'h104, 1, 1, 32'h00500093, 32'h104, 1);
    for (int i = 0; i < 5; i++) add(0, 1, 0, 32'h0, 32'h0, 1, 1, 32'h00500093, 32'h104, 1);
    add(0, 0, 0, 32'h0, 32'h0, 0, 0, NOP, 32'h0, 1);
    // Full queue: pop with push offered, push rejected.
    add(0, 1, 1, 32'hB0, 32'h20, 1, 1, 32'hB0, 32'h20, 1);
    add(0, 1, 1, 32'hB1, 32'h24, 2, 1, 32'hB0, 32'h20, 1);
    add(0, 1, 1, 32'hB2, 32'h28, 3, 1, 32'hB0, 32'h20, 1);
    add(0, 1, 1, 32'hB3, 32'h2c, 4, 1, 32'hB0, 32'h20, 0);
    add(0, 0, 1, 32'hB4, 32'h30, 3, 1, 32'hB1, 32'h24, 1);
    // Flush wins over push and stall with count=3; flushed push never appears.
    add(1, 1, 1, 32'hC0, 32'h34, 0, 0, NOP, 32'h0, 1);
    add(0, 0, 0, 32'h0,  32'h0,  0, 0, NOP, 32'h0, 1);
    add(0, 0, 1, 32'hD0, 32'h38, 1, 1, 32'hD0, 32'h38, 1);
    // Streaming push+pop at count=1 across three pointer wraps.
    for (int k = 0; k < 3 * DEPTH; k++)
      add(0, 0, 1, 32'hE00 + 32'(k), 32'h100 + 32'(4 * k), 1, 1, 32'hE00 + 32'(k),
          32'h100 + 32'(4 * k), 1);
    // Simultaneous push+pop at count=DEPTH-1.
    add(0, 1, 1, 32'hF0, 32'h200, 2, 1, 32'hE0B, 32'h12c, 1);
    add(0, 1, 1, 32'hF1, 32'h204, 3, 1, 32'hE0B, 32'h12c, 1);
    add(0, 0, 1, 32'hF2, 32'h208, 3, 1, 32'hF0,  32'h200, 1);
    add(0, 0, 0, 32'h0,  32'h0,   2, 1, 32'hF1,  32'h204, 1);
    add(0, 0, 0, 32'h0,  32'h0,   1, 1, 32'hF2,  32'h208, 1);
    add(0, 0, 0, 32'h0,  32'h0,   0, 0, NOP,     32'h0,   1);

    rst_n = 1'b0;
    drive(0, 0, 1, 32'hDEAD, 32'hBEEF);
    #2;
    check_all("reset", 0, 0, NOP, 32'h0, 1);
    @(posedge clk); #1;
    check_all("reset_edge", 0, 0, NOP, 32'h0, 1);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].flush, vecs[i].stall, vecs[i].valid, vecs[i].ins, vecs[i].pc);
      @(posedge clk); #1;
      check_all($sformatf("v%0d", i), vecs[i].exp_count, vecs[i].exp_valid, vecs[i].exp_ins,
                vecs[i].exp_pc, vecs[i].exp_ready);
    end

    // Asynchronous reset mid-run with three entries queued.
    drive(0, 1, 1, 32'h60, 32'h300); @(posedge clk); #1;
    drive(0, 1, 1, 32'h61, 32'h304); @(posedge clk); #1;
    drive(0, 1, 1, 32'h62, 32'h308); @(posedge clk); #1;
    check("pre_rst_count", 64'(count_out), 64'd3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all("async_rst", 0, 0, NOP, 32'h0, 1);
    drive(0, 0, 1, 32'h70, 32'h310);
    @(posedge clk); #1;
    check_all("rst_held", 0, 0, NOP, 32'h0, 1);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 1, 32'h80, 32'h400);
    @(posedge clk); #1;
    check_all("post_rst_push", 1, 1, 32'h80, 32'h400, 1);
    drive(0, 0, 0, 32'h0, 32'h0);
    @(posedge clk); #1;
    check_all("post_rst_pop", 0, 0, NOP, 32'h0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
